// File: rtl/sap_pkg.sv
// SAP-1 controller shared types: T-state encoding, opcode values, control word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sap_pkg;

    localparam int SAP_OPCODE_W = 4;
    localparam int SAP_RING_LEN = 6;

    typedef logic [SAP_OPCODE_W-1:0] opcode_t;

    // Encoding is chosen so the state value is directly the visible T-state number;
    // HALTED reads as 0.
    typedef enum logic [2:0] {
        HALTED = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        T5     = 3'd5,
        T6     = 3'd6
    } t_state_e;

    localparam opcode_t LDA_OP = 4'b0000;
    localparam opcode_t ADD_OP = 4'b0001;
    localparam opcode_t SUB_OP = 4'b0010;
    localparam opcode_t NOP_OP = 4'b0011;
    localparam opcode_t OUT_OP = 4'b1110;
    localparam opcode_t HLT_OP = 4'b1111;

    // One bit per datapath control line.
    typedef struct packed {
        logic pc_inc;    // Cp
        logic pc_out;    // Ep
        logic mar_load;  // Lm
        logic ram_out;   // CE
        logic ir_load;   // Li
        logic ir_out;    // Ei
        logic a_load;    // La
        logic a_out;     // Ea
        logic alu_sub;   // Su
        logic alu_out;   // Eu
        logic b_load;    // Lb
        logic out_load;  // Lo
    } ctrl_word_t;

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational control-word decode from current T-state and latched opcode.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module sap_ctrl_decode
    import sap_pkg::*;
(
    input  t_state_e   state_i,
    input  opcode_t    op_i,
    output ctrl_word_t ctrl_o
);

    // Fetch in T1..T3 is opcode independent; execute in T4..T6 keys off the latched opcode.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            T1: begin
                ctrl_o.pc_out   = 1'b1;
                ctrl_o.mar_load = 1'b1;
            end
            T2: begin
                ctrl_o.pc_inc = 1'b1;
            end
            T3: begin
                ctrl_o.ram_out = 1'b1;
                ctrl_o.ir_load = 1'b1;
            end
            T4: begin
                case (op_i)
                    LDA_OP, ADD_OP, SUB_OP: begin
                        ctrl_o.ir_out   = 1'b1;
                        ctrl_o.mar_load = 1'b1;
                    end
                    OUT_OP: begin
                        ctrl_o.a_out    = 1'b1;
                        ctrl_o.out_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (op_i)
                    LDA_OP: begin
                        ctrl_o.ram_out = 1'b1;
                        ctrl_o.a_load  = 1'b1;
                    end
                    ADD_OP, SUB_OP: begin
                        ctrl_o.ram_out = 1'b1;
                        ctrl_o.b_load  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (op_i)
                    ADD_OP: begin
                        ctrl_o.alu_out = 1'b1;
                        ctrl_o.a_load  = 1'b1;
                    end
                    SUB_OP: begin
                        ctrl_o.alu_out = 1'b1;
                        ctrl_o.a_load  = 1'b1;
                        ctrl_o.alu_sub = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;  // HALTED drives nothing
        endcase
    end

endmodule

// File: rtl/sap_controller.sv
// SAP-1 sequencer: six-state ring counter driving the W-bus control lines, with run/step/halt.
// Latency: control word appears one falling edge after an advance and is valid for one rising edge.
// Backpressure: no advance (run=0, no step edge) holds the T-state with all controls low.
module sap_controller
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int RING_LEN = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_inc,
    output logic                pc_out,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                alu_sub,
    output logic                alu_out,
    output logic                b_load,
    output logic                out_load,
    output logic                halted,
    output logic [2:0]          t_state
);

    t_state_e            state_q;
    logic [OPCODE_W-1:0] op_q;
    logic                ctrl_valid_q;
    logic                step_q;      // previous sample of step for edge detect
    logic                adv;
    ctrl_word_t          ctrl_dec;
    ctrl_word_t          ctrl_gated;

    // A run level or a fresh step edge advances exactly once per falling edge.
    assign adv = run | (step & ~step_q);

    // Sequencer on the falling edge so control lines are settled for the datapath's rising edge.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= T6;
            op_q         <= NOP_OP;
            ctrl_valid_q <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            step_q <= step;
            if (state_q == HALTED) begin
                // Only reset leaves HALTED; run and step are ignored.
                ctrl_valid_q <= 1'b0;
            end else if (adv) begin
                ctrl_valid_q <= 1'b1;
                case (state_q)
                    T1: state_q <= T2;
                    T2: state_q <= T3;
                    T3: begin
                        // IR was loaded at T3's rising edge, so opcode is now the new instruction.
                        op_q    <= opcode;
                        state_q <= (opcode == HLT_OP) ? HALTED : T4;
                    end
                    T4: state_q <= T5;
                    T5: state_q <= T6;
                    T6: state_q <= T1;
                    default: state_q <= HALTED;
                endcase
            end else begin
                // Holding: drop the word so nothing is loaded or incremented twice.
                ctrl_valid_q <= 1'b0;
            end
        end
    end

    sap_ctrl_decode u_decode (
        .state_i (state_q),
        .op_i    (op_q),
        .ctrl_o  (ctrl_dec)
    );

    // Control lines are live only in the cycle right after an advance.
    always_comb begin
        ctrl_gated = '0;
        if (ctrl_valid_q) begin
            ctrl_gated = ctrl_dec;
        end
    end

    assign pc_inc   = ctrl_gated.pc_inc;
    assign pc_out   = ctrl_gated.pc_out;
    assign mar_load = ctrl_gated.mar_load;
    assign ram_out  = ctrl_gated.ram_out;
    assign ir_load  = ctrl_gated.ir_load;
    assign ir_out   = ctrl_gated.ir_out;
    assign a_load   = ctrl_gated.a_load;
    assign a_out    = ctrl_gated.a_out;
    assign alu_sub  = ctrl_gated.alu_sub;
    assign alu_out  = ctrl_gated.alu_out;
    assign b_load   = ctrl_gated.b_load;
    assign out_load = ctrl_gated.out_load;
    assign halted   = (state_q == HALTED);
    assign t_state  = state_q;

    // Only one driver may own the W-bus when the datapath clocks.
    a_bus_exclusive: assert property (@(posedge clock) disable iff (reset)
        $onehot0({pc_out, ram_out, ir_out, a_out, alu_out}));

    // A control word is never presented without the advance that produced it.
    a_valid_needs_adv: assert property (@(negedge clock) disable iff (reset)
        !adv |=> !ctrl_valid_q);

    // The ring never leaves its RING_LEN states (or HALTED).
    a_ring_range: assert property (@(negedge clock) disable iff (reset)
        int'(state_q) <= RING_LEN);

endmodule

// File: tb/tb_sap_controller.sv
module tb_sap_controller;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Bit positions of the gathered control vector, pc_inc is the MSB.
    localparam logic [11:0] C_CP = 12'h800;
    localparam logic [11:0] C_EP = 12'h400;
    localparam logic [11:0] C_LM = 12'h200;
    localparam logic [11:0] C_CE = 12'h100;
    localparam logic [11:0] C_LI = 12'h080;
    localparam logic [11:0] C_EI = 12'h040;
    localparam logic [11:0] C_LA = 12'h020;
    localparam logic [11:0] C_EA = 12'h010;
    localparam logic [11:0] C_SU = 12'h008;
    localparam logic [11:0] C_EU = 12'h004;
    localparam logic [11:0] C_LB = 12'h002;
    localparam logic [11:0] C_LO = 12'h001;

    logic       clock = 1'b0;
    logic       reset, run, step;
    logic [3:0] opcode;
    logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, alu_sub, alu_out, b_load, out_load;
    logic       halted;
    logic [2:0] t_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];

    // Reference model state
    int         m_t  = 6;
    logic [3:0] m_op = 4'b0011;
    logic       m_v  = 1'b0;
    logic       m_sd = 1'b0;

    sap_controller dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .opcode   (opcode),
        .pc_inc   (pc_inc),
        .pc_out   (pc_out),
        .mar_load (mar_load),
        .ram_out  (ram_out),
        .ir_load  (ir_load),
        .ir_out   (ir_out),
        .a_load   (a_load),
        .a_out    (a_out),
        .alu_sub  (alu_sub),
        .alu_out  (alu_out),
        .b_load   (b_load),
        .out_load (out_load),
        .halted   (halted),
        .t_state  (t_state)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {halted, t_state, pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
                a_load, a_out, alu_sub, alu_out, b_load, out_load};
    endfunction

    function automatic logic [15:0] ev(input logic h, input int t, input logic [11:0] c);
        return {h, 3'(t), c};
    endfunction

    // Expected control word per instruction table
    function automatic logic [11:0] exp_ctrl(input int t, input logic [3:0] op);
        logic [11:0] r;
        r = 12'h000;
        case (t)
            1: r = C_EP | C_LM;
            2: r = C_CP;
            3: r = C_CE | C_LI;
            4: if (op == OP_LDA || op == OP_ADD || op == OP_SUB) r = C_EI | C_LM;
               else if (op == OP_OUT) r = C_EA | C_LO;
            5: if (op == OP_LDA) r = C_CE | C_LA;
               else if (op == OP_ADD || op == OP_SUB) r = C_CE | C_LB;
            6: if (op == OP_ADD) r = C_EU | C_LA;
               else if (op == OP_SUB) r = C_EU | C_LA | C_SU;
            default: r = 12'h000;
        endcase
        return r;
    endfunction

    // Model advances on each falling edge and queues what the DUT must show at the next rising edge.
    always @(negedge clock) begin
        logic adv;
        if (reset) begin
            m_t = 6; m_op = 4'b0011; m_v = 1'b0; m_sd = 1'b0;
        end else begin
            adv  = run || (step && !m_sd);
            m_sd = step;
            if (m_t == 0) begin
                m_v = 1'b0;
            end else if (adv) begin
                m_v = 1'b1;
                if (m_t == 3) begin
                    m_op = opcode;
                    m_t  = (opcode == OP_HLT) ? 0 : 4;
                end else begin
                    m_t = (m_t == 6) ? 1 : m_t + 1;
                end
            end else begin
                m_v = 1'b0;
            end
        end
        exp_q.push_back(ev(m_t == 0, m_t, m_v ? exp_ctrl(m_t, m_op) : 12'h000));
    end

    always @(posedge clock) begin
        logic [15:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("sb", dut_vec(), e);
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Run one full instruction in run mode, checking every T-state.
    task automatic run_instr(input string nm, input logic [3:0] op,
                             input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
        logic [11:0] e [1:6];
        e[1] = C_EP | C_LM; e[2] = C_CP; e[3] = C_CE | C_LI;
        e[4] = e4; e[5] = e5; e[6] = e6;
        opcode = op;
        for (int t = 1; t <= 6; t++) begin
            next_cycle();
            check_eq($sformatf("%s_T%0d", nm, t), dut_vec(), ev(1'b0, t, e[t]));
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; opcode = OP_LDA;
        repeat (3) next_cycle();
        check_eq("reset_state", dut_vec(), ev(1'b0, 6, 12'h000));

        // LDA in run mode
        reset = 1'b0; run = 1'b1;
        run_instr("lda", OP_LDA, C_EI | C_LM, C_CE | C_LA, 12'h000);

        // SUB with opcode changed during T5; the 7th edge above wraps to T1
        opcode = OP_SUB;
        next_cycle(); check_eq("wrap_T1", dut_vec(), ev(1'b0, 1, C_EP | C_LM));
        next_cycle(); check_eq("sub_T2", dut_vec(), ev(1'b0, 2, C_CP));
        next_cycle(); check_eq("sub_T3", dut_vec(), ev(1'b0, 3, C_CE | C_LI));
        next_cycle(); check_eq("sub_T4", dut_vec(), ev(1'b0, 4, C_EI | C_LM));
        next_cycle(); check_eq("sub_T5", dut_vec(), ev(1'b0, 5, C_CE | C_LB));
        opcode = OP_OUT;
        next_cycle(); check_eq("sub_T6_latched", dut_vec(), ev(1'b0, 6, C_EU | C_LA | C_SU));

        run_instr("add", OP_ADD, C_EI | C_LM, C_CE | C_LB, C_EU | C_LA);
        run_instr("out", OP_OUT, C_EA | C_LO, 12'h000, 12'h000);
        for (int op = 3; op <= 13; op++) begin
            run_instr($sformatf("nop%0d", op), 4'(op), 12'h000, 12'h000, 12'h000);
        end

        // Single step: three pulses each held 4 clocks
        run = 1'b0;
        next_cycle(); check_eq("idle_hold", dut_vec(), ev(1'b0, 6, 12'h000));
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            next_cycle();
            check_eq($sformatf("step%0d_adv", k), dut_vec(), ev(1'b0, k, exp_ctrl(k, OP_LDA)));
            repeat (3) begin
                next_cycle();
                check_eq($sformatf("step%0d_held", k), dut_vec(), ev(1'b0, k, 12'h000));
            end
            step = 1'b0;
            repeat (4) begin
                next_cycle();
                check_eq($sformatf("step%0d_idle", k), dut_vec(), ev(1'b0, k, 12'h000));
            end
        end

        // HLT
        reset = 1'b1; next_cycle(); reset = 1'b0;
        run = 1'b1; opcode = OP_HLT;
        repeat (3) next_cycle();
        next_cycle(); check_eq("hlt_enter", dut_vec(), ev(1'b1, 0, 12'h000));
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
            opcode = 4'($urandom_range(0, 15));
            next_cycle();
            check_eq("hlt_stay", dut_vec(), ev(1'b1, 0, 12'h000));
        end
        reset = 1'b1; #1;
        check_eq("hlt_reset_async", dut_vec(), ev(1'b0, 6, 12'h000));
        next_cycle(); reset = 1'b0; step = 1'b0;

        // Reset during T5 of ADD
        run = 1'b1; opcode = OP_ADD;
        repeat (5) next_cycle();
        check_eq("add_T5_pre", dut_vec(), ev(1'b0, 5, C_CE | C_LB));
        #1 reset = 1'b1;
        #1 check_eq("midrst_async", dut_vec(), ev(1'b0, 6, 12'h000));
        next_cycle(); reset = 1'b0;
        next_cycle(); check_eq("midrst_T1", dut_vec(), ev(1'b0, 1, C_EP | C_LM));

        // Random traffic, checked by the scoreboard
        for (int i = 0; i < 10000; i++) begin
            run    = ($urandom_range(0, 3) == 0);
            step   = 1'($urandom_range(0, 1));
            opcode = 4'($urandom_range(0, 15));
            reset  = ($urandom_range(0, 63) == 0);
            next_cycle();
        end
        reset = 1'b0;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
